// File: rtl/vreduction_sched.sv
// Round-robin scheduler that shares one vreduction unit among NUM_REQ requesters and routes results back by tag.
// Optional perf counters (perf_issued, perf_stall) are built when VRED_SCHED_PERF_EN is defined.
module vreduction_sched #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LANES        = 16,
    parameter int unsigned NUM_ELEMENTS = 32,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*2-1:0]              req_op,
    input  logic [NUM_REQ-1:0]                req_broadcast,
    input  logic [NUM_REQ-1:0]                req_clear,
    input  logic [NUM_REQ*5-1:0]              req_imm,
    input  logic [NUM_REQ*NUM_ELEMENTS*16-1:0] req_vector,
    output logic                              ru_input_valid,
    output logic [1:0]                        ru_reduction_type,
    output logic                              ru_broadcast,
    output logic                              ru_clear,
    output logic [4:0]                        ru_imm,
    output logic [NUM_ELEMENTS*16-1:0]        ru_vector_input,
    output logic [LANES*16-1:0]               ru_lane_input,
    input  logic                              ru_output_valid,
    input  logic [NUM_ELEMENTS*16-1:0]        ru_vector_output,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [NUM_ELEMENTS*16-1:0]        rsp_vector,
    input  logic                              drain,
    output logic                              drained,
    output logic                              err_underflow
`ifdef VRED_SCHED_PERF_EN
    ,
    output logic [31:0]                       perf_issued,
    output logic [31:0]                       perf_stall
`endif
);

    localparam int unsigned VEC_W  = NUM_ELEMENTS * 16;
    localparam int unsigned LANE_W = LANES * 16;
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [1:0]         w_op  [NUM_REQ];
    logic [4:0]         w_imm [NUM_REQ];
    logic [VEC_W-1:0]   w_vec [NUM_REQ];
    logic               w_can_grant;
    logic               w_gnt_found;
    logic [ID_W-1:0]    w_gnt_idx;
    int                 w_scan;
    logic               w_empty;
    logic               w_pop;
    logic [NUM_REQ-1:0] w_rsp_onehot;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_op[g]  = req_op[g*2 +: 2];
        assign w_imm[g] = req_imm[g*5 +: 5];
        assign w_vec[g] = req_vector[g*VEC_W +: VEC_W];
    end

    // Registered count gates grants, so a same-cycle pop never frees a slot early.
    assign w_can_grant = !RST && (r_state == ST_RUN) && (r_count < CNT_W'(MAX_INFLIGHT));
    assign w_empty     = (r_count == '0);
    assign w_pop       = ru_output_valid && !w_empty;

    // Round-robin search starting one past the last grant.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan      = 0;
        if (w_can_grant) begin
            for (int k = 1; k <= int'(NUM_REQ); k++) begin
                w_scan = (int'(r_rr_ptr) + k) % int'(NUM_REQ);
                if (!w_gnt_found && req_valid[ID_W'(w_scan)]) begin
                    w_gnt_found = 1'b1;
                    w_gnt_idx   = ID_W'(w_scan);
                end
            end
        end
    end

    always_comb begin
        w_rsp_onehot = '0;
        w_rsp_onehot[r_tag_mem[r_rd_ptr]] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (drain)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!drain) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        req_ready = '0;
        drained   = 1'b0;
        if (w_gnt_found) req_ready[w_gnt_idx] = 1'b1;
        drained = (r_state == ST_DRAIN) && w_empty;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ru_input_valid    <= 1'b0;
            ru_reduction_type <= '0;
            ru_broadcast      <= 1'b0;
            ru_clear          <= 1'b0;
            ru_imm            <= '0;
            ru_vector_input   <= '0;
            ru_lane_input     <= '0;
            rsp_valid         <= '0;
            rsp_vector        <= '0;
            err_underflow     <= 1'b0;
            r_rr_ptr          <= ID_W'(NUM_REQ - 1);
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_count           <= '0;
            for (int i = 0; i < int'(MAX_INFLIGHT); i++) r_tag_mem[i] <= '0;
        end else begin
            ru_input_valid <= w_gnt_found;
            if (w_gnt_found) begin
                ru_reduction_type   <= w_op[w_gnt_idx];
                ru_broadcast        <= req_broadcast[w_gnt_idx];
                ru_clear            <= req_clear[w_gnt_idx];
                ru_imm              <= w_imm[w_gnt_idx];
                ru_vector_input     <= w_vec[w_gnt_idx];
                ru_lane_input       <= w_vec[w_gnt_idx][LANE_W-1:0];
                r_tag_mem[r_wr_ptr] <= w_gnt_idx;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
                r_rr_ptr            <= w_gnt_idx;
            end
            rsp_valid <= w_pop ? w_rsp_onehot : '0;
            if (w_pop) begin
                rsp_vector <= ru_vector_output;
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
            end
            if (ru_output_valid && w_empty) err_underflow <= 1'b1;
            case ({w_gnt_found, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef VRED_SCHED_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (w_gnt_found) perf_issued <= perf_issued + 32'd1;
            if ((|req_valid) && !w_gnt_found) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vreduction_sched.sv
// Self-checking bench for vreduction_sched: queue-based reference model, randomized traffic and directed scenarios.
module tb_vreduction_sched;

    localparam int NR = 4;
    localparam int L  = 16;
    localparam int NE = 32;
    localparam int MI = 4;
    localparam int VW = NE * 16;
    localparam int LW = L * 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*2-1:0]   req_op;
    logic [NR-1:0]     req_broadcast;
    logic [NR-1:0]     req_clear;
    logic [NR*5-1:0]   req_imm;
    logic [NR*VW-1:0]  req_vector;
    logic              ru_input_valid;
    logic [1:0]        ru_reduction_type;
    logic              ru_broadcast;
    logic              ru_clear;
    logic [4:0]        ru_imm;
    logic [VW-1:0]     ru_vector_input;
    logic [LW-1:0]     ru_lane_input;
    logic              ru_output_valid;
    logic [VW-1:0]     ru_vector_output;
    logic [NR-1:0]     rsp_valid;
    logic [VW-1:0]     rsp_vector;
    logic              drain;
    logic              drained;
    logic              err_underflow;
`ifdef VRED_SCHED_PERF_EN
    logic [31:0]       perf_issued;
    logic [31:0]       perf_stall;
`endif

    vreduction_sched #(.NUM_REQ(NR), .LANES(L), .NUM_ELEMENTS(NE), .MAX_INFLIGHT(MI)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_broadcast(req_broadcast), .req_clear(req_clear), .req_imm(req_imm),
        .req_vector(req_vector),
        .ru_input_valid(ru_input_valid), .ru_reduction_type(ru_reduction_type),
        .ru_broadcast(ru_broadcast), .ru_clear(ru_clear), .ru_imm(ru_imm),
        .ru_vector_input(ru_vector_input), .ru_lane_input(ru_lane_input),
        .ru_output_valid(ru_output_valid), .ru_vector_output(ru_vector_output),
        .rsp_valid(rsp_valid), .rsp_vector(rsp_vector),
        .drain(drain), .drained(drained), .err_underflow(err_underflow)
`ifdef VRED_SCHED_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Requester-side payload held by the bench
    bit            pv   [NR];
    logic [1:0]    pop_ [NR];
    bit            pbc  [NR];
    bit            pclr [NR];
    logic [4:0]    pim  [NR];
    logic [VW-1:0] pvec [NR];

    // Reference model state
    int            m_rr;
    int            m_tags[$];
    bit            m_drain;
    bit            m_err;
    bit            e_ruv;
    logic [1:0]    e_op;
    bit            e_bc;
    bit            e_clr;
    logic [4:0]    e_imm;
    logic [VW-1:0] e_vec;
    logic [NR-1:0] e_rsp;
    logic [VW-1:0] e_rspv;
    logic [31:0]   m_iss;
    logic [31:0]   m_stl;
    int            hs_idx = -1;
    logic [VW-1:0] u_q[$];

    // Single compare process: checks outputs, then advances the model to the next edge.
    always @(negedge CLK) begin
        int g;
        int idx;
        logic [NR-1:0] er;
        if (RST) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_ru_input_valid", ru_input_valid, 0);
            chk("rst_ru_vector_input", ru_vector_input, 0);
            chk("rst_ru_imm", ru_imm, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_vector", rsp_vector, 0);
            chk("rst_drained", drained, 0);
            chk("rst_err_underflow", err_underflow, 0);
            m_rr = NR - 1; m_tags.delete(); m_drain = 0; m_err = 0;
            e_ruv = 0; e_rsp = '0; hs_idx = -1; m_iss = 0; m_stl = 0;
        end else begin
            g = -1;
            if (!m_drain && m_tags.size() < MI) begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (m_rr + k) % NR;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("drained", drained, m_drain && m_tags.size() == 0);
            chk("ru_input_valid", ru_input_valid, e_ruv);
            if (e_ruv) begin
                chk("ru_reduction_type", ru_reduction_type, e_op);
                chk("ru_broadcast", ru_broadcast, e_bc);
                chk("ru_clear", ru_clear, e_clr);
                chk("ru_imm", ru_imm, e_imm);
                chk("ru_vector_input", ru_vector_input, e_vec);
                chk("ru_lane_input", ru_lane_input, e_vec[LW-1:0]);
                u_q.push_back(e_vec);
            end
            chk("rsp_valid", rsp_valid, e_rsp);
            if (e_rsp != 0) chk("rsp_vector", rsp_vector, e_rspv);
            chk("err_underflow", err_underflow, m_err);
`ifdef VRED_SCHED_PERF_EN
            chk("perf_issued", perf_issued, m_iss);
            chk("perf_stall", perf_stall, m_stl);
`endif
            e_ruv = (g >= 0);
            if (g >= 0) begin
                e_op = pop_[g]; e_bc = pbc[g]; e_clr = pclr[g]; e_imm = pim[g]; e_vec = pvec[g];
                m_rr = g; m_iss = m_iss + 1;
            end else if (|req_valid) begin
                m_stl = m_stl + 1;
            end
            e_rsp = '0;
            if (ru_output_valid) begin
                if (m_tags.size() > 0) begin
                    e_rsp[m_tags.pop_front()] = 1'b1;
                    e_rspv = ru_vector_output;
                end else begin
                    m_err = 1;
                end
            end
            if (g >= 0) m_tags.push_back(g);
            m_drain = drain;
            hs_idx  = g;
        end
    end

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic new_payload(input int i);
        pop_[i] = 2'($urandom_range(0, 3));
        pbc[i]  = 1'($urandom_range(0, 1));
        pclr[i] = 1'($urandom_range(0, 1));
        pim[i]  = 5'($urandom_range(0, 31));
        pvec[i] = rand_vec();
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = pv[i];
            req_op[i*2 +: 2]       = pop_[i];
            req_broadcast[i]       = pbc[i];
            req_clear[i]           = pclr[i];
            req_imm[i*5 +: 5]      = pim[i];
            req_vector[i*VW +: VW] = pvec[i];
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd_req(input int p);
        if (hs_idx >= 0) begin
            new_payload(hs_idx);
            pv[hs_idx] = ($urandom_range(0, 99) < p);
        end
        for (int i = 0; i < NR; i++) begin
            if (!pv[i] && $urandom_range(0, 99) < p) begin
                new_payload(i);
                pv[i] = 1;
            end
        end
        drive_bus();
    endtask

    task automatic unit_step(input int p);
        if (u_q.size() > 0 && $urandom_range(0, 99) < p) begin
            ru_output_valid  = 1'b1;
            ru_vector_output = ~u_q.pop_front();
        end else begin
            ru_output_valid = 1'b0;
        end
    endtask

    task automatic all_valid(input bit v);
        for (int i = 0; i < NR; i++) pv[i] = v;
        drive_bus();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        ru_output_valid = 1'b0;
        drain = 1'b0;
        all_valid(0);
        repeat (2) tick();
        u_q.delete();
        RST = 1'b0;
    endtask

    task automatic flush(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            upd_req(0);
            unit_step(100);
            tick();
        end
        ru_output_valid = 1'b0;
    endtask

    initial begin
        int            gseq[6];
        int            exp3[6];
        logic [VW-1:0] res;
        logic [VW-1:0] tmp;
        int            p_req;
        int            p_ret;
        bit            done;

        exp3 = '{0, 1, 2, 3, -1, -1};
        for (int i = 0; i < NR; i++) new_payload(i);
        ru_vector_output = '0;
        do_reset();

        // Single request from requester 2: op=min, imm=5
        pv[2] = 1; pop_[2] = 2'b01; pim[2] = 5'd5; pclr[2] = 0; pbc[2] = 0; pvec[2] = rand_vec();
        drive_bus();
        tick();
        chk("single_ru_valid", ru_input_valid, 1);
        chk("single_ru_imm", ru_imm, 5);
        chk("single_ru_type", ru_reduction_type, 2'b01);
        pv[2] = 0; drive_bus();
        tick();
        res = u_q.pop_front();
        res[5*16 +: 16] = 16'h3c00;
        ru_output_valid = 1'b1; ru_vector_output = res;
        tick();
        chk("single_rsp_valid", rsp_valid, 4'b0100);
        chk("single_rsp_vector", rsp_vector, res);
        ru_output_valid = 1'b0;
        tick();
        chk("single_rsp_clear", rsp_valid, 0);

        // Burst from all requesters until the tag FIFO is full
        do_reset();
        all_valid(1);
        for (int c = 0; c < 6; c++) begin
            tick();
            gseq[c] = hs_idx;
            if (hs_idx >= 0) new_payload(hs_idx);
            drive_bus();
        end
        for (int c = 0; c < 6; c++) chk($sformatf("burst_grant_%0d", c), 32'(gseq[c]), 32'(exp3[c]));
        ru_output_valid = 1'b1; ru_vector_output = ~u_q.pop_front();
        tick();
        chk("full_pop_no_grant", 32'(hs_idx), 32'(-1));
        chk("full_pop_rsp", rsp_valid, 4'b0001);
        ru_output_valid = 1'b0;
        tick();
        chk("full_next_grant", 32'(hs_idx), 32'(0));
        if (hs_idx >= 0) new_payload(hs_idx);
        all_valid(0);
        flush(20);

        // Drain with three requests in flight, underflow, then resume
        do_reset();
        all_valid(1);
        tick();
        tick();
        drain = 1'b1;
        tick();
        chk("drain_last_grant", 32'(hs_idx), 32'(2));
        tick();
        chk("drain_nogrant_a", 32'(hs_idx), 32'(-1));
        chk("drain_busy", drained, 0);
        tick();
        chk("drain_nogrant_b", 32'(hs_idx), 32'(-1));
        for (int r = 0; r < 3; r++) begin
            ru_output_valid = 1'b1; ru_vector_output = ~u_q.pop_front();
            tick();
            chk($sformatf("drain_rsp_%0d", r), rsp_valid, 4'(1 << r));
            chk($sformatf("drain_drained_%0d", r), drained, (r == 2));
        end
        ru_output_valid = 1'b1; ru_vector_output = rand_vec();
        tick();
        chk("underflow_set", err_underflow, 1);
        chk("underflow_no_rsp", rsp_valid, 0);
        ru_output_valid = 1'b0;
        tick();
        tick();
        chk("underflow_sticky", err_underflow, 1);
        drain = 1'b0;
        tick();
        tick();
        chk("resume_rr", 32'(hs_idx), 32'(3));
        all_valid(0);
        flush(10);

        // Randomized traffic with drain toggling and an asynchronous reset mid-stream
        do_reset();
        p_req = 60; p_ret = 60;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                p_req = $urandom_range(10, 100);
                p_ret = $urandom_range(20, 100);
            end
            if ($urandom_range(0, 99) < 2) drain = ~drain;
            upd_req(p_req);
            unit_step(p_ret);
            tick();
            if (c == 1500) begin
                #2;
                RST = 1'b1;
                #1;
                chk("async_rst_req_ready", req_ready, 0);
                chk("async_rst_ru_valid", ru_input_valid, 0);
                chk("async_rst_ru_vector", ru_vector_input, 0);
                chk("async_rst_rsp_valid", rsp_valid, 0);
                chk("async_rst_rsp_vector", rsp_vector, 0);
                chk("async_rst_err", err_underflow, 0);
                @(posedge CLK);
                #1;
                u_q.delete();
                ru_output_valid = 1'b0;
                drain = 1'b0;
                all_valid(0);
                tick();
                RST = 1'b0;
            end
        end

        // Final drain must complete within a bounded number of cycles
        drain = 1'b1;
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            upd_req(0);
            unit_step(100);
            tick();
            if (drained && u_q.size() == 0) done = 1;
        end
        ru_output_valid = 1'b0;
        chk("final_drain_done", done, 1);
        tmp = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
